// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD game timer.
//   bcd_digit_t : one packed BCD digit
//   BCD_MAX     : largest legal digit value (9)
//   BCD_ZERO    : smallest digit value (0)
//   bcd_clamp() : forces an illegal digit (A..F) down to 9
package bcd_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit BCD increment/decrement cell.
// Ports:
//   i_digit : current digit value
//   i_en    : carry (up) or borrow (down) in from the next-lower digit
//   i_down  : 0 = increment, 1 = decrement
//   o_digit : next digit value
//   o_carry : carry/borrow out to the next-higher digit
module bcd_digit_step
  import bcd_timer_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_en,
  input  logic       i_down,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  always_comb begin
    o_digit = i_digit;
    o_carry = 1'b0;
    if (i_en) begin
      if (i_down) begin
        o_carry = (i_digit == BCD_ZERO);
        o_digit = (i_digit == BCD_ZERO) ? BCD_MAX : i_digit - 4'd1;
      end else begin
        o_carry = (i_digit == BCD_MAX);
        o_digit = (i_digit == BCD_MAX) ? BCD_ZERO : i_digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_game_timer.sv
// Packed-BCD game timer with prescaler, up/down mode, pause, lap capture and
// sticky expiry. All outputs are registered.
// Ports:
//   system_clock_in : clock
//   reset_in        : asynchronous active-high reset
//   clear_in        : synchronous clear/load strobe (latches mode_down_in)
//   run_in          : count enable, low pauses the prescaler
//   mode_down_in    : 0 = count up, 1 = count down (sampled on clear_in)
//   load_bcd_in     : countdown start value (digits > 9 clamp to 9)
//   lap_in          : lap capture strobe
//   time_bcd_out    : current time, digit 0 in [3:0]
//   lap_bcd_out     : last captured lap time
//   lap_valid_out   : one-cycle pulse on lap capture
//   tick_out        : one-cycle pulse after each time step
//   expired_out     : sticky terminal-count flag
module bcd_game_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned TICK_DIV = 65_000_000,
  parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
  input  logic                  system_clock_in,
  input  logic                  reset_in,
  input  logic                  clear_in,
  input  logic                  run_in,
  input  logic                  mode_down_in,
  input  logic [4*DIGITS-1:0]   load_bcd_in,
  input  logic                  lap_in,
  output logic [4*DIGITS-1:0]   time_bcd_out,
  output logic [4*DIGITS-1:0]   lap_bcd_out,
  output logic                  lap_valid_out,
  output logic                  tick_out,
  output logic                  expired_out
);

  localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]    r_prescale;
  logic                r_mode_down;
  logic [4*DIGITS-1:0] r_time;
  logic [4*DIGITS-1:0] r_lap;
  logic                r_lap_valid;
  logic                r_tick;
  logic                r_expired;

  logic [4*DIGITS-1:0] w_time_next;
  logic [4*DIGITS-1:0] w_load_clamped;
  logic [4*DIGITS-1:0] w_all_nines;
  logic [DIGITS:0]     w_carry;
  logic                w_load_zero;
  logic                w_terminal;

  // Ripple chain: digit 0 always steps, higher digits step on carry/borrow.
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .i_digit (r_time[4*g +: 4]),
      .i_en    (w_carry[g]),
      .i_down  (r_mode_down),
      .o_digit (w_time_next[4*g +: 4]),
      .o_carry (w_carry[g+1])
    );
    assign w_load_clamped[4*g +: 4] = bcd_clamp(load_bcd_in[4*g +: 4]);
    assign w_all_nines[4*g +: 4]    = BCD_MAX;
  end

  assign w_load_zero = (w_load_clamped == '0);

  // Terminal value reached on this step. The top carry/borrow can only fire
  // past the terminal value, which expiry already prevents; it is folded in
  // so a wrap could never go unflagged.
  assign w_terminal = (r_mode_down ? (w_time_next == '0) : (w_time_next == w_all_nines))
                      | w_carry[DIGITS];

  always_ff @(posedge system_clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_prescale  <= '0;
      r_mode_down <= 1'b0;
      r_time      <= '0;
      r_lap       <= '0;
      r_lap_valid <= 1'b0;
      r_tick      <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_tick      <= 1'b0;
      r_lap_valid <= 1'b0;
      if (clear_in) begin
        // Clear wins over lap and step on the same edge.
        r_mode_down <= mode_down_in;
        r_prescale  <= '0;
        if (mode_down_in) begin
          r_time    <= w_load_clamped;
          r_expired <= w_load_zero;
        end else begin
          r_time    <= '0;
          r_expired <= 1'b0;
        end
      end else begin
        if (lap_in) begin
          r_lap       <= r_time;
          r_lap_valid <= 1'b1;
        end
        if (run_in && !r_expired) begin
          if (r_prescale == PRE_MAX) begin
            r_prescale <= '0;
            r_time     <= w_time_next;
            r_tick     <= 1'b1;
            if (w_terminal) begin
              r_expired <= 1'b1;
            end
          end else begin
            r_prescale <= r_prescale + 1'b1;
          end
        end
      end
    end
  end

  assign time_bcd_out  = r_time;
  assign lap_bcd_out   = r_lap;
  assign lap_valid_out = r_lap_valid;
  assign tick_out      = r_tick;
  assign expired_out   = r_expired;

endmodule

// File: doc/bcd_game_timer.md
# bcd_game_timer

Parametrised BCD game timer that counts elapsed or remaining play time in packed BCD. It supports a configurable digit count and prescale divisor, count-up or count-down mode, pause/resume, lap capture and expiry flagging. It sits between game control (clear/run/lap strobes) and the existing 8-digit hex display driver, which consumes `time_bcd_out` or `lap_bcd_out` directly.

## Interface
- `DIGITS`, 8: number of BCD digits, 1..8.
- `TICK_DIV`, 65_000_000: clock cycles per count unit; must be ≥ 2.
- `DIV_W`, `$clog2(TICK_DIV)`: prescaler width (derived, not overridden).
- `system_clock_in` in 1: system clock.
- `reset_in` in 1: asynchronous, active-high reset.
- `clear_in` in 1: synchronous clear/load strobe.
- `run_in` in 1: count enable; low pauses.
- `mode_down_in` in 1: 0 = count up, 1 = count down; sampled only on `clear_in`.
- `load_bcd_in` in 4*DIGITS: countdown start value; sampled on `clear_in` when `mode_down_in`=1.
- `lap_in` in 1: lap capture strobe.
- `time_bcd_out` out 4*DIGITS: current time, packed BCD, digit 0 in [3:0].
- `lap_bcd_out` out 4*DIGITS: last captured lap time.
- `lap_valid_out` out 1: one-cycle pulse when `lap_bcd_out` updates.
- `tick_out` out 1: one-cycle pulse on every time step.
- `expired_out` out 1: sticky; cleared only by `clear_in` or reset.

## Operation
- Reset: all outputs, the prescaler and the latched mode register go to 0, and mode becomes up. Reset takes effect immediately, mid-count included.
- Clear in up mode:
  - time goes to 0, prescaler to 0, `expired_out` to 0.
  - the latched mode is set from `mode_down_in`.
- Clear in down mode:
  - time is loaded from `load_bcd_in` with each digit > 9 clamped to 9.
  - `expired_out` is set to 1 if the clamped load is all zero, otherwise 0.
  - the latched mode is set from `mode_down_in`.
- Prescaler:
  - advances only when `run_in`=1 and `expired_out`=0.
  - counts 0..TICK_DIV-1 and wraps to 0.
  - the edge that wraps it also steps the time and pulses `tick_out`.
  - the step period is therefore exactly TICK_DIV enabled cycles.
- Pause: `run_in`=0 freezes the prescaler value; it is not reset.
- Up step: BCD ripple increment. A digit advances when all lower digits are 9, and 9 wraps to 0.
  - If the result would be all 9s, the time is set to all 9s and `expired_out` rises on the same edge.
  - Counting then stops.
- Down step: BCD ripple decrement. A digit decrements when all lower digits are 0, and 0 wraps to 9.
  - On reaching all zeros, `expired_out` rises on the same edge and counting stops.
- Lap: on `lap_in`, `lap_bcd_out` is set to the `time_bcd_out` value present before the edge, and `lap_valid_out` pulses. Lap capture works while paused or expired.
- Priority within one edge: reset > clear > step/lap.
  - `clear_in` together with `lap_in`: the clear wins, there is no lap capture and no `lap_valid_out`.
  - A step together with a lap: the lap holds the pre-step value.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `clear_in` to new time: 1 cycle. The first step follows TICK_DIV enabled cycles after the clear edge.
- `tick_out` is high for exactly the cycle after the stepping edge, coincident with the new `time_bcd_out`.
- `lap_in` to `lap_bcd_out`/`lap_valid_out`: 1 cycle.
- No `tick_out` is generated while `expired_out`=1.
- Continuous `clear_in` holds the time at the clear value, with no ticks.

## Structure
- Package `bcd_timer_pkg`:
  - `bcd_digit_t` (logic [3:0]).
  - function `bcd_clamp` (digit > 9 gives 9).
  - constants `BCD_MAX` = 4'd9 and `BCD_ZERO` = 4'd0.
- Sub-module `bcd_digit_step`:
  - combinational single digit, with inputs digit, enable (carry/borrow in) and down.
  - outputs are the next digit and carry/borrow out.
  - instantiated DIGITS times via generate and chained from digit 0.
- The top level holds the prescaler, the time/lap/mode/expired registers and the priority logic.

## Test plan
All scenarios use DIGITS=3 and TICK_DIV=4.
- Up count: reset, clear, run high for 40 cycles -> `time_bcd_out`=12'h010, `tick_out` pulses exactly every 4 cycles, 10 pulses in total.
- Carry and saturation: run up from 0 to 12'h099 and then one more step -> 12'h100. Continue to 12'h999 -> `expired_out`=1 on that edge, with no further ticks for 100 cycles.
- Down count and clamping:
  - load 12'h102 with down mode -> steps 101, 100, 099.
  - load 12'h001 -> after 4 cycles, 000 with `expired_out`=1.
  - load 12'h0A5 -> 12'h095.
  - load 12'h000 -> `expired_out`=1 one cycle after the clear.
- Pause: drop `run_in` for 10 cycles when the prescaler is at 2 -> the next tick is delayed exactly 10 cycles and the time is unchanged during the pause.
- Lap priority:
  - `lap_in` on a stepping edge from 12'h017 -> `lap_bcd_out`=12'h017 and time 12'h018.
  - `lap_in` together with `clear_in` -> no `lap_valid_out`, and the time clears.
- Asynchronous reset: assert `reset_in` mid-prescale, away from a clock edge -> all outputs are 0 before the next edge. Deassert -> the mode is up and counting resumes from 0 after clear/run.
